// File: rtl/snake_tile_scheduler.sv
// Pixel-write arbiter for the snake game: grants erase/head/apple tile requests by fixed
// priority and sweeps each granted tile row-major, one pixel per clock. Optional SNAKE_TILE_CLIP_EN.
module snake_tile_scheduler #(
  parameter int          XDIM         = 10,
  parameter int          YDIM         = 10,
  parameter int          XSCREEN      = 160,
  parameter int          YSCREEN      = 120,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] ers_x,
  input  logic [6:0] ers_y,
  input  logic [7:0] head_x,
  input  logic [6:0] head_y,
  input  logic [2:0] head_colour,
  input  logic [7:0] apple_x,
  input  logic [6:0] apple_y,
  input  logic [2:0] apple_colour,
  output logic       busy,
  output logic [2:0] done,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [3:0] XLAST = 4'(XDIM - 1);
  localparam logic [3:0] YLAST = 4'(YDIM - 1);
  localparam bit PARAMS_OK = (XDIM >= 1) && (XDIM <= 16) && (YDIM >= 1) && (YDIM <= 16) &&
                             (XSCREEN >= 1) && (XSCREEN <= 256) &&
                             (YSCREEN >= 1) && (YSCREEN <= 128);

  // An out-of-range parameter set elaborates a missing module and stops the build.
  if (!PARAMS_OK) begin : g_bad_params
    snake_tile_scheduler_param_range_error u_param_error ();
  end

  state_t     state_q, state_d;
  logic [3:0] xc_q, xc_d;
  logic [3:0] yc_q, yc_d;
  logic [7:0] ox_q, ox_d;
  logic [6:0] oy_q, oy_d;
  logic [2:0] colour_q, colour_d;
  logic [2:0] grant_q, grant_d;  // one-hot, same bit order as req

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    xc_d     = xc_q;
    yc_d     = yc_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    colour_d = colour_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SWEEP;
          xc_d    = '0;
          yc_d    = '0;
          if (req[0]) begin
            grant_d  = 3'b001;
            ox_d     = ers_x;
            oy_d     = ers_y;
            colour_d = ERASE_COLOUR;
          end else if (req[1]) begin
            grant_d  = 3'b010;
            ox_d     = head_x;
            oy_d     = head_y;
            colour_d = head_colour;
          end else begin
            grant_d  = 3'b100;
            ox_d     = apple_x;
            oy_d     = apple_y;
            colour_d = apple_colour;
          end
        end
      end
      SWEEP: begin
        if (xc_q == XLAST) begin
          xc_d = '0;
          if (yc_q == YLAST) begin
            state_d = DONE;
          end else begin
            yc_d = yc_q + 4'd1;
          end
        end else begin
          xc_d = xc_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        yc_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers, including the
  // latched tile data, are reset so the pixel outputs read zero the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      xc_q     <= '0;
      yc_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      colour_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      xc_q     <= xc_d;
      yc_q     <= yc_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      colour_q <= colour_d;
      grant_q  <= grant_d;
    end
  end

`ifdef SNAKE_TILE_CLIP_EN
  // Unwrapped sums so off-screen pixels can be suppressed instead of wrapping around.
  logic [8:0] px_x;
  logic [7:0] px_y;
  assign px_x  = {1'b0, ox_q} + {5'b0, xc_q};
  assign px_y  = {1'b0, oy_q} + {4'b0, yc_q};
  assign vga_x = px_x[7:0];
  assign vga_y = px_y[6:0];
  assign plot  = (state_q == SWEEP) && (px_x < 9'(XSCREEN)) && (px_y < 8'(YSCREEN));
`else
  assign vga_x = ox_q + {4'b0, xc_q};
  assign vga_y = oy_q + {3'b0, yc_q};
  assign plot  = (state_q == SWEEP);
`endif

  assign vga_colour = colour_q;
  assign busy       = (state_q == SWEEP) || (state_q == DONE);
  assign done       = (state_q == DONE) ? grant_q : 3'b000;

endmodule

// File: tb/tb_snake_tile_scheduler.sv
// Directed bench for snake_tile_scheduler: timing, priority, pending requests, reset abort,
// wrap/clip behaviour and input isolation during a sweep.
module tb_snake_tile_scheduler;

  localparam int XD = 10;
  localparam int YD = 10;
  localparam int N  = XD * YD;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [7:0] ers_x, head_x, apple_x;
  logic [6:0] ers_y, head_y, apple_y;
  logic [2:0] head_colour, apple_colour;
  logic       busy, plot;
  logic [2:0] done, vga_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  snake_tile_scheduler #(
    .XDIM(XD), .YDIM(YD), .XSCREEN(160), .YSCREEN(120), .ERASE_COLOUR(3'b000)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .ers_x(ers_x), .ers_y(ers_y),
    .head_x(head_x), .head_y(head_y), .head_colour(head_colour),
    .apple_x(apple_x), .apple_y(apple_y), .apple_colour(apple_colour),
    .busy(busy), .done(done), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called during the IDLE cycle that samples req; returns early in the cycle after DONE.
  task automatic run_tile(input string tag, input logic [7:0] ox, input logic [6:0] oy,
                          input logic [2:0] col, input logic [2:0] done_exp);
    int bad = 0;
    int plots = 0;
    int exp_plots = 0;
    int ex, ey, idx;
    bit ep;
    @(posedge clk);
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      idx = k - 1;
      ex  = int'(ox) + idx % XD;
      ey  = int'(oy) + idx / XD;
`ifdef SNAKE_TILE_CLIP_EN
      ep = (ex < 160) && (ey < 120);
`else
      ep = 1'b1;
`endif
      ex = ex % 256;
      ey = ey % 128;
      if (plot !== ep || busy !== 1'b1 || done !== 3'b000) bad++;
      if (ep && (vga_x !== ex[7:0] || vga_y !== ey[6:0] || vga_colour !== col)) bad++;
      if (ep) exp_plots++;
      if (plot === 1'b1) plots++;
    end
    check({tag, " pixel errors"}, bad, 0);
    check({tag, " plot count"}, plots, exp_plots);
    @(negedge clk);
    check({tag, " done pulse"}, {29'b0, done}, {29'b0, done_exp});
    check({tag, " plot in DONE"}, {31'b0, plot}, 0);
    check({tag, " busy in DONE"}, {31'b0, busy}, 1);
    req = req & ~done;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, " busy idle"}, {31'b0, busy}, 0);
    check({tag, " done idle"}, {29'b0, done}, 0);
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    ers_x = 8'd0;  ers_y = 7'd0;
    head_x = 8'd0; head_y = 7'd0; head_colour = 3'd0;
    apple_x = 8'd0; apple_y = 7'd0; apple_colour = 3'd0;

    repeat (3) @(negedge clk);
    check("reset plot", {31'b0, plot}, 0);
    check("reset vga_x", {24'b0, vga_x}, 0);
    check("reset vga_y", {25'b0, vga_y}, 0);
    check("reset colour", {29'b0, vga_colour}, 0);
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {29'b0, done}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single head tile.
    head_x = 8'd39; head_y = 7'd59; head_colour = 3'b010;
    req = 3'b010;
    run_tile("head", 8'd39, 7'd59, 3'b010, 3'b010);
    check_idle("head");

    // All three at once: erase, head, apple back to back.
    ers_x = 8'd10; ers_y = 7'd20;
    apple_x = 8'd100; apple_y = 7'd50; apple_colour = 3'b101;
    req = 3'b111;
    run_tile("prio erase", 8'd10, 7'd20, 3'b000, 3'b001);
    run_tile("prio head", 8'd39, 7'd59, 3'b010, 3'b010);
    run_tile("prio apple", 8'd100, 7'd50, 3'b101, 3'b100);
    check_idle("prio");

    // Head raised mid-apple-sweep waits for apple to finish.
    apple_x = 8'd20; apple_y = 7'd30; apple_colour = 3'b110;
    req = 3'b100;
    fork
      run_tile("pend apple", 8'd20, 7'd30, 3'b110, 3'b100);
      begin
        repeat (31) @(posedge clk);
        #1;
        head_x = 8'd60; head_y = 7'd70; head_colour = 3'b011;
        req[1] = 1'b1;
      end
    join
    run_tile("pend head", 8'd60, 7'd70, 3'b011, 3'b010);
    check_idle("pend");

    // Origin/colour changes during a sweep are ignored.
    head_x = 8'd80; head_y = 7'd60; head_colour = 3'b001;
    req = 3'b010;
    fork
      run_tile("latch", 8'd80, 7'd60, 3'b001, 3'b010);
      begin
        repeat (20) @(posedge clk);
        #1;
        head_x = 8'd0; head_y = 7'd0; head_colour = 3'b111;
      end
    join
    check_idle("latch");

    // Reset at sweep cycle 50, then restart from the origin.
    head_x = 8'd39; head_y = 7'd59; head_colour = 3'b010;
    req = 3'b010;
    @(posedge clk);
    repeat (49) @(posedge clk);
    @(negedge clk);
    check("abort pre plot", {31'b0, plot}, 1);
    #1 rst = 1'b1;
    #1;
    check("abort plot", {31'b0, plot}, 0);
    check("abort vga_x", {24'b0, vga_x}, 0);
    check("abort vga_y", {25'b0, vga_y}, 0);
    check("abort busy", {31'b0, busy}, 0);
    check("abort done", {29'b0, done}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_tile("restart", 8'd39, 7'd59, 3'b010, 3'b010);
    check_idle("restart");

    // Apple near the screen corner.
    apple_x = 8'd155; apple_y = 7'd115; apple_colour = 3'b100;
    req = 3'b100;
    run_tile("corner", 8'd155, 7'd115, 3'b100, 3'b100);
    check_idle("corner");

    // Erase tile that wraps both coordinates.
    ers_x = 8'd250; ers_y = 7'd125;
    req = 3'b001;
    run_tile("wrap", 8'd250, 7'd125, 3'b000, 3'b001);
    check_idle("wrap");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/snake_tile_scheduler.md
# snake_tile_scheduler

Arbitrates the single VGA adapter pixel-write port between the three tile requesters of the snake game: tail erase, head draw and apple draw. A granted request is expanded into an XDIM×YDIM raster sweep, one pixel per clock. The block sits between the game-logic FSM and `vga_adapter`, and is the only driver of its `plot`/`x`/`y`/`colour` inputs.

## Interface
Parameters:
- XDIM, 10: tile width in pixels (1..16).
- YDIM, 10: tile height in pixels (1..16).
- XSCREEN, 160: screen width; used only with clipping.
- YSCREEN, 120: screen height; used only with clipping.
- ERASE_COLOUR, 3'b000: colour driven for erase tiles.

Ports:
- Clock  in  1  system clock (CLOCK_50 domain).
- Reset  in  1  asynchronous, active-high reset.
- req  in  3  request lines: bit0 erase, bit1 head, bit2 apple.
- ers_x / head_x / apple_x  in  8 each  tile origin X per requester.
- ers_y / head_y / apple_y  in  7 each  tile origin Y per requester.
- head_colour / apple_colour  in  3 each  draw colour.
- busy  out  1  high in SWEEP and DONE.
- done  out  3  one-hot, one-cycle completion pulse, same bit order as req.
- plot  out  1  pixel-write enable to vga_adapter.
- vga_x  out  8  pixel X.
- vga_y  out  7  pixel Y.
- vga_colour  out  3  pixel colour.

## Operation
- States: IDLE, SWEEP, DONE. Resets to IDLE.
- IDLE, req==0: stay in IDLE.
- IDLE, any req bit set:
  - Grant by fixed priority: erase > head > apple.
  - Latch granted origin, colour (ERASE_COLOUR for erase) and grant index.
  - Clear xc and yc. Go to SWEEP.
- SWEEP:
  - plot=1. vga_x = ox+xc (mod 256), vga_y = oy+yc (mod 128), vga_colour = latched colour.
  - xc increments each cycle. At XDIM-1, xc returns to 0 and yc increments.
  - When xc==XDIM-1 and yc==YDIM-1: go to DONE.
- DONE: done[grant]=1 and plot=0. Go to IDLE.
- Requesters hold req high with stable origin/colour until their done bit pulses, then deassert req on the next edge.
  - A req still high in IDLE after its own done is served again. This is legal, not an error.
- Non-granted requests stay pending and are not lost. Apple may starve under continuous erase/head traffic; that is the accepted policy.
- Input changes during SWEEP have no effect, because all tile data is latched at grant.
- All outputs derive from registers only; there is no combinational input-to-output path.
- Reset values: plot=0, vga_x=0, vga_y=0, vga_colour=0, busy=0, done=000. xc, yc and the latched origin are cleared.
- Reset mid-sweep: outputs return to reset values immediately (asynchronous). The aborted tile gets no done pulse; its requester must re-request.

## Timing
- Cycle 0: IDLE samples req.
- Cycles 1..N: SWEEP, with N = XDIM·YDIM. Exactly N plot cycles, row-major from (ox,oy) to (ox+XDIM-1, oy+YDIM-1).
- Cycle N+1: DONE.
- Cycle N+2: IDLE. The earliest next grant edge is the end of cycle N+2.
- Back-to-back tile throughput: N+2 cycles per tile. 100 plots per 102 cycles at default parameters.
- Counter widths: xc and yc are 4 bits, sized for dimensions up to 16.

## Configuration
- SNAKE_TILE_CLIP_EN defined:
  - Origin sums are computed unwrapped (9-bit X, 8-bit Y).
  - plot is forced to 0 for pixels with x ≥ XSCREEN or y ≥ YSCREEN.
  - Sweep length and done timing are unchanged.
- SNAKE_TILE_CLIP_EN undefined:
  - plot=1 on every SWEEP cycle.
  - Coordinates wrap modulo 256 / 128.

## Test plan
- Reset, then head req with origin (39,59) and colour 3'b010 → plot high for exactly 100 cycles. First pixel (39,59), 11th pixel (39,60), last (48,68). done=010 at cycle 101. busy low at cycle 102.
- req=111 asserted together → grant order is erase (colour 000), then head, then apple. done pulses 001, 010, 100 at cycles 101, 203, 305.
- Apple req held, head req raised mid-sweep → apple tile completes uninterrupted. Head is granted on the IDLE cycle after apple's done.
- Reset asserted at sweep cycle 50 → plot, vga_x, vga_y and busy are 0 in the same cycle. No done pulse. After release with req still high, the tile restarts from (ox,oy).
- Apple at (155,115):
  - With SNAKE_TILE_CLIP_EN: 25 plot cycles, all with x ≤ 159 and y ≤ 119. done at cycle 101.
  - Without it: 100 plot cycles, all coordinates equal to origin+offset under the mod-256/mod-128 wrap rule.
- Origin inputs changed to (0,0) during a sweep from (80,60) → all 100 pixels stay within the (80..89, 60..69) tile.
